// File: rtl/stopwatch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : stopwatch_ctrl                                         |
// | Description : Button-driven control FSM for a BCD stopwatch, with    |
// |               lap freeze and a saturating lap counter.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module stopwatch_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [3:0] milSec0,
    output logic       start_resume,
    output logic       stop,
    output logic       sw_reset,
    output logic [3:0] d_min0,
    output logic [3:0] d_sec1,
    output logic [3:0] d_sec0,
    output logic [3:0] d_milSec0,
    output logic       running,
    output logic       lap_active,
    output logic [3:0] lap_count
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RUNNING = 2'd1;
    localparam logic [1:0] c_ST_PAUSED  = 2'd2;
    localparam logic [1:0] c_ST_LAP     = 2'd3;
    localparam logic [3:0] c_LAP_MAX    = 4'd15;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_ss_prev;
    logic        r_lr_prev;
    logic        w_ss_ev;
    logic        w_lr_ev;
    logic        w_start_nxt;
    logic        w_stop_nxt;
    logic        w_swrst_nxt;
    logic        w_capture;
    logic        w_clear;
    logic        r_start_resume;
    logic        r_stop;
    logic        r_sw_reset;
    logic [15:0] r_lap;
    logic [3:0]  r_lap_count;

    // Previous samples track the buttons even in reset so a held button is not an event.
    always_ff @(posedge clk) begin
        r_ss_prev <= btn_ss;
        r_lr_prev <= btn_lr;
    end

    assign w_ss_ev = btn_ss & ~r_ss_prev;
    assign w_lr_ev = btn_lr & ~r_lr_prev & ~w_ss_ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_ss_ev) w_state_nxt = c_ST_RUNNING;
            c_ST_RUNNING: if (w_ss_ev) w_state_nxt = c_ST_PAUSED;
                          else if (w_lr_ev) w_state_nxt = c_ST_LAP;
            c_ST_PAUSED:  if (w_ss_ev) w_state_nxt = c_ST_RUNNING;
                          else if (w_lr_ev) w_state_nxt = c_ST_IDLE;
            c_ST_LAP:     if (w_ss_ev) w_state_nxt = c_ST_PAUSED;
                          else if (w_lr_ev) w_state_nxt = c_ST_RUNNING;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_start_nxt = 1'b0;
        w_stop_nxt  = 1'b0;
        w_swrst_nxt = 1'b0;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_start_nxt = w_ss_ev;
                w_swrst_nxt = w_lr_ev;
            end
            c_ST_RUNNING: begin
                w_stop_nxt = w_ss_ev;
                w_capture  = w_lr_ev;
            end
            c_ST_PAUSED: begin
                w_start_nxt = w_ss_ev;
                w_swrst_nxt = w_lr_ev;
                w_clear     = w_lr_ev;
            end
            c_ST_LAP: begin
                w_stop_nxt = w_ss_ev;
            end
            default: ;
        endcase
    end

    // Command pulses come out of flops; sw_reset stays high through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_resume <= 1'b0;
            r_stop         <= 1'b0;
            r_sw_reset     <= 1'b1;
            r_lap          <= 16'd0;
            r_lap_count    <= 4'd0;
        end else begin
            r_start_resume <= w_start_nxt;
            r_stop         <= w_stop_nxt;
            r_sw_reset     <= w_swrst_nxt;
            if (w_clear) begin
                r_lap       <= 16'd0;
                r_lap_count <= 4'd0;
            end else if (w_capture) begin
                r_lap <= {min0, sec1, sec0, milSec0};
                if (r_lap_count != c_LAP_MAX) begin
                    r_lap_count <= r_lap_count + 4'd1;
                end
            end
        end
    end

    assign start_resume = r_start_resume;
    assign stop         = r_stop;
    assign sw_reset     = r_sw_reset;
    assign running      = (r_state == c_ST_RUNNING) || (r_state == c_ST_LAP);
    assign lap_active   = (r_state == c_ST_LAP);
    assign lap_count    = r_lap_count;

    assign {d_min0, d_sec1, d_sec0, d_milSec0} =
        lap_active ? r_lap : {min0, sec1, sec0, milSec0};

endmodule
`default_nettype wire
